uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 136 +++++++++++++
 tb/tb_uart_receiver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a single-entry
// holding register flagged by RX_STATUS and cleared by RX_ACK.
module uart_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      os_cnt_q, os_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_status_q, rx_status_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            tick;
  logic            mid;

  assign tick = (state_q != IDLE) && (tick_cnt_q == TICK_MAX);
  assign mid  = tick && (os_cnt_q == 4'd7);

  // NOTE: every signal gets a default before the case statement, so no path
  // through this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    rx_meta_d   = UART_RX;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    os_cnt_d    = tick ? os_cnt_q + 4'd1 : os_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_status_d = rx_status_q && !RX_ACK;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        os_cnt_d   = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // The oversample counter keeps running from here, so data samples
        // land 16 ticks apart on the centre of each bit.
        if (mid) begin
          if (rx_s_q) begin
            state_d  = IDLE;
            os_cnt_d = '0;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (mid) begin
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP: begin
        if (mid) begin
          state_d  = IDLE;
          os_cnt_d = '0;
          if (rx_s_q) begin
            // A byte landing together with RX_ACK simply replaces the old one.
            rx_data_d   = shift_q;
            rx_status_d = 1'b1;
            overrun_d   = rx_status_q && !RX_ACK;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign RX_DATA   = rx_data_q;
  assign RX_STATUS = rx_status_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized bench for uart_receiver; expected bytes, flags and
// pulse counts come from a frame-level model of the receive/ack protocol.
module tb_uart_receiver;

  localparam int CLK_FREQ = 614400;
  localparam int BAUD     = 9600;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC  = 16 * DIV;
  localparam int LAT      = (19 * BIT_CYC) / 2 + 3;
  localparam int CLK_PER  = 10;

  logic       sysclk;
  logic       reset;
  logic       UART_RX;
  logic       RX_ACK;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  fe_cnt   = 0;
  int  ov_cnt   = 0;
  int  busy_rises = 0;
  time t_start  = 0;
  time t_rise   = 0;
  time t_busy_fall = 0;

  logic [7:0] exp_data;
  logic       exp_status;
  int         exp_ov;
  int         exp_fe;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .RX_ACK   (RX_ACK),
    .RX_DATA  (RX_DATA),
    .RX_STATUS(RX_STATUS),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial sysclk = 1'b0;
  always #(CLK_PER / 2) sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end
  always @(posedge RX_STATUS) t_rise = $time;
  always @(negedge busy) t_busy_fall = $time;
  always @(posedge busy) busy_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame (start, 8 data LSB first, stop) followed by one idle bit.
  // With noisy set, each bit carries a short inverted pulse near its start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic noisy);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(posedge sysclk); #1 UART_RX = frame[k];
      if (k == 0) t_start = $time;
      if (noisy && k > 0) begin
        repeat (4) @(posedge sysclk);
        #1 UART_RX = ~frame[k];
        repeat (3) @(posedge sysclk);
        #1 UART_RX = frame[k];
        repeat (BIT_CYC - 8) @(posedge sysclk);
      end else begin
        repeat (BIT_CYC - 1) @(posedge sysclk);
      end
    end
    @(posedge sysclk); #1 UART_RX = 1'b1;
    repeat (BIT_CYC - 1) @(posedge sysclk);
  endtask

  task automatic ack_pulse();
    @(posedge sysclk); #1 RX_ACK = 1'b1;
    @(posedge sysclk); #1 RX_ACK = 1'b0;
  endtask

  // Frame-level reference: a good frame delivers its byte; it overruns only if
  // an unacknowledged byte is pending and no ack arrives with it.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic ack_with);
    if (stop_ok) begin
      if (exp_status && !ack_with) exp_ov++;
      exp_data   = b;
      exp_status = 1'b1;
    end else begin
      exp_fe++;
    end
  endtask

  initial begin
    int fe0, ov0, br0;
    logic [7:0] rb;
    logic stop_ok, noisy, do_ack;

    reset   = 1'b0;
    RX_ACK  = 1'b0;
    UART_RX = 1'b0;
    exp_data = 8'h00; exp_status = 1'b0; exp_ov = 0; exp_fe = 0;

    // Reset holds outputs regardless of line activity.
    for (int i = 0; i < 6; i++) begin
      @(posedge sysclk); #1 UART_RX = 1'($urandom_range(0, 1));
    end
    @(negedge sysclk);
    check("reset_rx_data", 32'(RX_DATA), 32'h00);
    check("reset_rx_status", 32'(RX_STATUS), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    @(posedge sysclk); #1 UART_RX = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 reset = 1'b1;
    repeat (8) @(posedge sysclk);

    // Basic reception of 0xA5 with latency measurement.
    t_rise = 0; t_busy_fall = 0; fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    model_frame(8'hA5, 1'b1, 1'b0);
    @(negedge sysclk);
    check("a5_data", 32'(RX_DATA), 32'(exp_data));
    check("a5_status", 32'(RX_STATUS), 32'(exp_status));
    check("a5_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("a5_status_latency", 32'((t_rise - t_start + 1) / CLK_PER), 32'(LAT));
    check("a5_busy_fall", 32'((t_busy_fall - t_start + 1) / CLK_PER), 32'(LAT));
    check("a5_busy_idle", 32'(busy), 32'h0);

    ack_pulse();
    exp_status = 1'b0;
    @(negedge sysclk);
    check("ack_clears_status", 32'(RX_STATUS), 32'(exp_status));
    check("ack_keeps_data", 32'(RX_DATA), 32'(exp_data));
    ack_pulse();
    @(negedge sysclk);
    check("ack_when_empty", 32'(RX_STATUS), 32'h0);

    // Short low glitch on an idle line is rejected at start mid-bit.
    br0 = busy_rises;
    @(posedge sysclk); #1 UART_RX = 1'b0;
    repeat (3 * DIV) @(posedge sysclk);
    #1 UART_RX = 1'b1;
    repeat (BIT_CYC) @(posedge sysclk);
    @(negedge sysclk);
    check("glitch_busy_pulse", 32'(busy_rises - br0), 32'd1);
    check("glitch_busy_idle", 32'(busy), 32'h0);
    check("glitch_status", 32'(RX_STATUS), 32'h0);
    check("glitch_data", 32'(RX_DATA), 32'(exp_data));

    // Bad stop bit: one frame_err pulse, holding register untouched.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (BIT_CYC) @(posedge sysclk);
    @(negedge sysclk);
    check("badstop_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("badstop_data", 32'(RX_DATA), 32'(exp_data));
    check("badstop_status", 32'(RX_STATUS), 32'(exp_status));
    check("badstop_busy", 32'(busy), 32'h0);

    // Two bytes without ack: second overwrites, one overrun pulse.
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b0);
    @(negedge sysclk);
    check("overrun_data", 32'(RX_DATA), 32'(exp_data));
    check("overrun_status", 32'(RX_STATUS), 32'(exp_status));
    check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
    ack_pulse();
    exp_status = 1'b0;
    @(negedge sysclk);
    check("overrun_ack", 32'(RX_STATUS), 32'(exp_status));

    // Ack on the exact completion cycle of 0x7E: new byte wins, no overrun.
    rb = 8'($urandom);
    send_frame(rb, 1'b1, 1'b0);
    model_frame(rb, 1'b1, 1'b0);
    ov0 = ov_cnt;
    fork
      send_frame(8'h7E, 1'b1, 1'b0);
      begin
        @(posedge sysclk);
        repeat (LAT - 1) @(posedge sysclk);
        #1 RX_ACK = 1'b1;
        @(posedge sysclk); #1 RX_ACK = 1'b0;
      end
    join
    model_frame(8'h7E, 1'b1, 1'b1);
    @(negedge sysclk);
    check("ackcoinc_status", 32'(RX_STATUS), 32'(exp_status));
    check("ackcoinc_data", 32'(RX_DATA), 32'(exp_data));
    check("ackcoinc_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset during data bit 4 of 0xFF abandons the frame.
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        @(posedge sysclk);
        repeat (5 * BIT_CYC + 31) @(posedge sysclk);
        @(negedge sysclk);
        check("midreset_busy_before", 32'(busy), 32'h1);
        @(posedge sysclk); #1 reset = 1'b0;
        repeat (2) @(negedge sysclk);
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_status", 32'(RX_STATUS), 32'h0);
        check("midreset_data", 32'(RX_DATA), 32'h00);
        repeat (4) @(posedge sysclk);
        #1 reset = 1'b1;
      end
    join
    exp_data = 8'h00; exp_status = 1'b0;
    @(negedge sysclk);
    check("midreset_no_byte", 32'(RX_STATUS), 32'h0);
    send_frame(8'h55, 1'b1, 1'b0);
    model_frame(8'h55, 1'b1, 1'b0);
    @(negedge sysclk);
    check("after_reset_data", 32'(RX_DATA), 32'(exp_data));
    check("after_reset_status", 32'(RX_STATUS), 32'(exp_status));
    check("after_reset_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("after_reset_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Randomized frames, acks, bad stops and between-sample line noise.
    exp_ov = 0; exp_fe = 0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 12; i++) begin
      rb      = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      noisy   = 1'($urandom_range(0, 1));
      do_ack  = 1'($urandom_range(0, 1));
      if (do_ack) begin
        ack_pulse();
        exp_status = 1'b0;
      end
      send_frame(rb, stop_ok, noisy);
      model_frame(rb, stop_ok, 1'b0);
      if (!stop_ok) repeat (BIT_CYC) @(posedge sysclk);
      @(negedge sysclk);
      check("rand_data", 32'(RX_DATA), 32'(exp_data));
      check("rand_status", 32'(RX_STATUS), 32'(exp_status));
      check("rand_overrun", 32'(ov_cnt - ov0), 32'(exp_ov));
      check("rand_frame_err", 32'(fe_cnt - fe0), 32'(exp_fe));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
